async_fifo_gray: RTL
====================

Name: async_fifo_gray

Overview:
Dual-clock FIFO carrying DATA_WIDTH-bit words from the w_clk domain to the r_clk domain. It uses gray-coded pointers and multi-flop synchronisers for safe clock-domain crossing. Depth is a power of two, and each side has its own occupancy count, almost flags and error pulses. It is the general-purpose CDC buffer for every design that moves data between unrelated clocks.

Parameters:
DATA_WIDTH, 8, word width in bits
ADDR_WIDTH, 3, log2 of depth; DEPTH = 2**ADDR_WIDTH (ADDR_WIDTH >= 2)
SYNC_STAGES, 2, flops per pointer synchroniser (>= 2)
AF_MARGIN, 1, almost_full when wr_count >= DEPTH - AF_MARGIN
AE_MARGIN, 1, almost_empty when rd_count <= AE_MARGIN

Ports:
w_clk  in  1  write clock
r_clk  in  1  read clock
rst  in  1  reset, asynchronous, active-low, common to both domains
we  in  1  write request (w_clk)
din  in  DATA_WIDTH  write data
full  out  1  no free slot (w_clk, registered)
almost_full  out  1  see AF_MARGIN (w_clk)
wr_count  out  ADDR_WIDTH+1  write-side occupancy, conservative high
overflow  out  1  one-cycle pulse: write attempted while full
re  in  1  read request (r_clk)
dout  out  DATA_WIDTH  read data, registered
empty  out  1  no data (r_clk, registered)
almost_empty  out  1  see AE_MARGIN (r_clk)
rd_count  out  ADDR_WIDTH+1  read-side occupancy, conservative low
underflow  out  1  one-cycle pulse: read attempted while empty

Behaviour:
- Reset is asynchronous, active-low and common to both domains. Assertion immediately clears all of the following:
  - binary and gray pointers in both domains
  - all synchroniser flops
  - dout=0, full=0, almost_full=0, empty=1, almost_empty=1
  - wr_count=0, rd_count=0, overflow=0, underflow=0
- Deassertion is resynchronised separately in each domain by a 2-flop reset synchroniser.
- Memory contents are not reset.
- Pointers are ADDR_WIDTH+1 bits wide and kept in both binary and gray. The MSB is the wrap bit; the low ADDR_WIDTH bits address memory.
- Write: on a w_clk edge with we && !full, store din at wbin[ADDR_WIDTH-1:0] and advance wbin/wgray by 1.
- Write with we && full:
  - data is dropped and pointers are unchanged
  - overflow=1 for exactly that cycle
- Read: on an r_clk edge with re && !empty, dout <= mem[rbin[ADDR_WIDTH-1:0]] and rbin/rgray advance. Latency is 1 r_clk.
- Read with re && empty:
  - dout holds its previous value and pointers are unchanged
  - underflow=1 for exactly that cycle
- CDC:
  - wgray passes through SYNC_STAGES r_clk flops to give rq_wgray.
  - rgray passes through SYNC_STAGES w_clk flops to give wq_rgray.
  - Only gray values cross domains; no binary value crosses.
- full is registered. Next value = (wgray_next == {~wq_rgray[MSB:MSB-1], wq_rgray[MSB-2:0]}). full asserts on the same edge that writes the last free slot.
- empty is registered. Next value = (rgray_next == rq_wgray). empty asserts on the same edge that reads the last word.
- Counts:
  - wr_count = wbin - gray2bin(wq_rgray), range 0..DEPTH.
  - rd_count = gray2bin(rq_wgray) - rbin.
  - Both are modulo 2**(ADDR_WIDTH+1).
  - Occupancy may be stale by SYNC_STAGES+1 cycles of the opposite clock, always in the safe direction.
- Crossing latency:
  - A write into an empty FIFO deasserts empty within SYNC_STAGES+1 r_clk edges.
  - A read from a full FIFO deasserts full within SYNC_STAGES+1 w_clk edges.
- Wrap-around: pointers wrap naturally. Full vs empty is distinguished only by the MSB (wrap bit).
- Simultaneous write and read (either domain, any phase) is always legal. Data order is strictly FIFO.
- Reset mid-operation: stored data is discarded, and flags go to their reset values asynchronously. The first write after reset release lands in slot 0.
- Synthesis and simulation must not use $display or any other non-synthesisable construct in the RTL.

Decomposition:
- Package async_fifo_pkg holds:
  - functions bin2gray(logic [N:0]) and gray2bin, parametrised by width via a localparam-driven typedef
  - constant DEFAULT_SYNC_STAGES = 2
- Sub-module sync_nff (parameters WIDTH, STAGES): an N-flop synchroniser with async active-low clear. It is instantiated twice for pointers and twice for resets (WIDTH=1).

Test Plan:
Defaults throughout: DATA_WIDTH=8, ADDR_WIDTH=3 (DEPTH=8); w_clk 10 ns, r_clk 17 ns.
1. Reset: drive rst=0 for 3 cycles of each clock -> empty=1, full=0, almost_empty=1, wr_count=0, rd_count=0, dout=0, overflow=0, underflow=0.
2. Fill: write 0x11,0x22..0x88 with re=0 -> wr_count=7 and almost_full=1 after 7th write; full=1 after 8th write; 9th write of 0x99 -> overflow pulse 1 cycle, wr_count stays 8.
3. Drain: re=1 for 9 reads -> dout sequence 0x11..0x88, each one r_clk after its read edge; empty=1 after 8th read; 9th read -> underflow pulse, dout stays 0x88.
4. Latency: single write 0xA5 into empty FIFO -> empty falls within 3 r_clk edges; rd_count=1; read returns 0xA5.
5. Wrap/concurrent: 40 writes of incrementing bytes 0x00..0x27 with random we/re gaps, both sides running -> read sequence 0x00..0x27 exact, no overflow/underflow, pointers wrap ≥4 times.
6. Reset mid-operation: 5 words stored, pulse rst low -> empty=1, full=0 immediately; write 0x3C after release -> read returns 0x3C, then empty=1.

Source files
------------

// File: rtl/async_fifo_pkg.sv
// Shared helpers for the dual-clock FIFO: gray/binary conversion and defaults.
package async_fifo_pkg;

  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int GRAY_MAX_W = 32;

  typedef logic [GRAY_MAX_W-1:0] gray_t;

  // Callers zero-extend narrower pointers into gray_t and truncate the result.
  function automatic gray_t bin2gray(input gray_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic gray_t gray2bin(input gray_t gray);
    gray_t bin;
    bin = gray;
    for (int i = 1; i < GRAY_MAX_W; i++) begin
      bin = bin ^ (gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/async_fifo_gray_sync_nff.sv
// N-flop synchroniser with asynchronous active-low clear.
module sync_nff
  import async_fifo_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_r [STAGES];

  // Shift chain; only the last stage is consumed by the destination domain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      stage_r[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign q = stage_r[STAGES-1];

endmodule

// File: rtl/async_fifo_gray.sv
// Dual-clock FIFO with gray-coded pointer crossing, per-side occupancy and flags.
module async_fifo_gray
  import async_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 3,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int AF_MARGIN   = 1,
  parameter int AE_MARGIN   = 1
) (
  input  logic                  w_clk,
  input  logic                  r_clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_count,
  output logic                  overflow,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   rd_count,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam int MSB   = ADDR_WIDTH;
  localparam logic [PTR_W-1:0] AF_LIM = PTR_W'(DEPTH - AF_MARGIN);
  localparam logic [PTR_W-1:0] AE_LIM = PTR_W'(AE_MARGIN);

  logic w_rst_s, r_rst_s;
  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  logic [PTR_W-1:0] wbin_r, wgray_r, wq_rgray_s;
  logic [PTR_W-1:0] wbin_next_s, wgray_next_s, wq_rbin_s, wr_count_next_s;
  logic             wr_inc_s, full_next_s;
  logic             full_r, almost_full_r, overflow_r;
  logic [PTR_W-1:0] wr_count_r;

  logic [PTR_W-1:0] rbin_r, rgray_r, rq_wgray_s;
  logic [PTR_W-1:0] rbin_next_s, rgray_next_s, rq_wbin_s, rd_count_next_s;
  logic             rd_inc_s, empty_next_s;
  logic             empty_r, almost_empty_r, underflow_r;
  logic [PTR_W-1:0] rd_count_r;
  logic [DATA_WIDTH-1:0] dout_r;

  // Reset asserts asynchronously in both domains but releases on each local clock.
  sync_nff #(.WIDTH(1), .STAGES(2)) u_w_rst_sync (
    .clk(w_clk), .rst(rst), .d(1'b1), .q(w_rst_s)
  );
  sync_nff #(.WIDTH(1), .STAGES(2)) u_r_rst_sync (
    .clk(r_clk), .rst(rst), .d(1'b1), .q(r_rst_s)
  );

  sync_nff #(.WIDTH(PTR_W), .STAGES(SYNC_STAGES)) u_rgray_to_w (
    .clk(w_clk), .rst(w_rst_s), .d(rgray_r), .q(wq_rgray_s)
  );
  sync_nff #(.WIDTH(PTR_W), .STAGES(SYNC_STAGES)) u_wgray_to_r (
    .clk(r_clk), .rst(r_rst_s), .d(wgray_r), .q(rq_wgray_s)
  );

  // Write-side next state; full compares against the synchronised read pointer.
  always_comb begin
    wr_inc_s        = we & ~full_r;
    wbin_next_s     = wbin_r + PTR_W'(wr_inc_s);
    wgray_next_s    = PTR_W'(bin2gray(gray_t'(wbin_next_s)));
    wq_rbin_s       = PTR_W'(gray2bin(gray_t'(wq_rgray_s)));
    full_next_s     = (wgray_next_s == {~wq_rgray_s[MSB:MSB-1], wq_rgray_s[MSB-2:0]});
    wr_count_next_s = wbin_next_s - wq_rbin_s;
  end

  // Write-domain registers and flags.
  always_ff @(posedge w_clk or negedge w_rst_s) begin
    if (!w_rst_s) begin
      wbin_r        <= {PTR_W{1'b0}};
      wgray_r       <= {PTR_W{1'b0}};
      full_r        <= 1'b0;
      almost_full_r <= 1'b0;
      wr_count_r    <= {PTR_W{1'b0}};
      overflow_r    <= 1'b0;
    end else begin
      wbin_r        <= wbin_next_s;
      wgray_r       <= wgray_next_s;
      full_r        <= full_next_s;
      almost_full_r <= (wr_count_next_s >= AF_LIM);
      wr_count_r    <= wr_count_next_s;
      overflow_r    <= we & full_r;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge w_clk) begin
    if (wr_inc_s) begin
      mem_r[wbin_r[ADDR_WIDTH-1:0]] <= din;
    end
  end

  // Read-side next state; empty compares against the synchronised write pointer.
  always_comb begin
    rd_inc_s        = re & ~empty_r;
    rbin_next_s     = rbin_r + PTR_W'(rd_inc_s);
    rgray_next_s    = PTR_W'(bin2gray(gray_t'(rbin_next_s)));
    rq_wbin_s       = PTR_W'(gray2bin(gray_t'(rq_wgray_s)));
    empty_next_s    = (rgray_next_s == rq_wgray_s);
    rd_count_next_s = rq_wbin_s - rbin_next_s;
  end

  // Read-domain registers, flags and registered data output.
  always_ff @(posedge r_clk or negedge r_rst_s) begin
    if (!r_rst_s) begin
      rbin_r         <= {PTR_W{1'b0}};
      rgray_r        <= {PTR_W{1'b0}};
      empty_r        <= 1'b1;
      almost_empty_r <= 1'b1;
      rd_count_r     <= {PTR_W{1'b0}};
      underflow_r    <= 1'b0;
      dout_r         <= {DATA_WIDTH{1'b0}};
    end else begin
      rbin_r         <= rbin_next_s;
      rgray_r        <= rgray_next_s;
      empty_r        <= empty_next_s;
      almost_empty_r <= (rd_count_next_s <= AE_LIM);
      rd_count_r     <= rd_count_next_s;
      underflow_r    <= re & empty_r;
      if (rd_inc_s) begin
        dout_r <= mem_r[rbin_r[ADDR_WIDTH-1:0]];
      end
    end
  end

  assign full         = full_r;
  assign almost_full  = almost_full_r;
  assign wr_count     = wr_count_r;
  assign overflow     = overflow_r;
  assign dout         = dout_r;
  assign empty        = empty_r;
  assign almost_empty = almost_empty_r;
  assign rd_count     = rd_count_r;
  assign underflow    = underflow_r;

endmodule
